// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam int NUM_VECTORS           = 8;
  localparam int VEC_W                 = 3;
  localparam int DEFAULT_SETTLE_CYCLES = 4;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts enabled cycles from a load and flags the terminal count.
// Usable by any sweep controller that must hold a stimulus for a fixed time.
module truth_table_sequencer_settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  // Wide enough to hold SETTLE_CYCLES itself, so the count can never wrap.
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count up from zero after a load and stop at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (enable && !tc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// Hardware sweep of a 3-input combinational block: drives all eight input
// vectors, samples F after a settle window, and checks the resulting table.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; last results held on the outputs
//   SETTLE | current vector driven, waiting for F to settle
//   SAMPLE | F captured into the table, then advance or finish
//   DONE   | one-cycle completion pulse, pass/mismatch valid
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_VECTORS-1:0] expected,
  input  logic                   F,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] mismatch
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

  seq_state_e             state_q, state_d;
  logic [VEC_W-1:0]       idx_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [NUM_VECTORS-1:0] table_q;
  logic [NUM_VECTORS-1:0] table_next;
  logic                   pass_q;
  logic [NUM_VECTORS-1:0] mismatch_q;

  logic timer_load;
  logic timer_en;
  logic timer_tc;
  logic accept;
  logic sample_en;
  logic advance;
  logic finish;

  truth_table_sequencer_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    accept     = 1'b0;
    sample_en  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      timer_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = SETTLE;
            accept     = 1'b1;
            timer_load = 1'b1;
          end
        end
        SETTLE: begin
          timer_en = 1'b1;
          if (timer_tc) state_d = SAMPLE;
        end
        SAMPLE: begin
          sample_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            finish  = 1'b1;
          end else begin
            state_d    = SETTLE;
            advance    = 1'b1;
            timer_load = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Table with the current vector's F merged in; the last sample feeds the
  // pass/mismatch result directly so they are valid during the done pulse.
  always_comb begin
    table_next        = table_q;
    table_next[idx_q] = F;
  end

  // Vector index, captured expectation, sampled table and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      exp_q      <= '0;
      table_q    <= '0;
      pass_q     <= 1'b0;
      mismatch_q <= '0;
    end else begin
      if (abort) begin
        idx_q <= '0;
      end
      if (accept) begin
        idx_q   <= '0;
        table_q <= '0;
        exp_q   <= expected;
      end
      if (sample_en) begin
        table_q <= table_next;
      end
      if (advance) begin
        idx_q <= idx_q + VEC_W'(1);
      end
      if (finish) begin
        pass_q     <= (table_next == exp_q);
        mismatch_q <= table_next ^ exp_q;
      end
    end
  end

  // The vector index is itself the registered stimulus, A as MSB.
  assign {A, B, C}  = idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign table_out  = table_q;
  assign pass       = pass_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with F = A&B | ~C (table 8'hD5).
// u0 uses the default settle time (4), u1 the minimum (1).
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, abort0, F0, A0, B0, C0, busy0, done0, pass0;
  logic [7:0] exp0, tbl0, mm0;
  logic       start1, abort1, F1, A1, B1, C1, busy1, done1, pass1;
  logic [7:0] exp1, tbl1, mm1;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign F0 = (A0 & B0) | ~C0;
  assign F1 = (A1 & B1) | ~C1;

  truth_table_sequencer #(.SETTLE_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0),
    .F(F0), .A(A0), .B(B0), .C(C0), .busy(busy0), .done(done0),
    .table_out(tbl0), .pass(pass0), .mismatch(mm0)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .F(F1), .A(A1), .B(B1), .C(C1), .busy(busy1), .done(done1),
    .table_out(tbl1), .pass(pass1), .mismatch(mm1)
  );

  // Pulse start for one edge (edge 0); returns 1 ns after that edge.
  task automatic start_sweep(input bit sel, input logic [7:0] e);
    @(negedge clk);
    if (sel) begin start1 = 1'b1; exp1 = e; end
    else     begin start0 = 1'b1; exp0 = e; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Watch n_edges edges after the start edge, recording done activity and
  // deviations of the vector and busy from the ideal sweep timeline.
  task automatic observe(input bit sel, input int s, input int n_edges, input int pulse_at,
                         output int done_edge, output int done_cnt,
                         output int vec_err, output int busy_err);
    logic [2:0] v;
    logic       d, b;
    int         ev;
    done_edge = -1; done_cnt = 0; vec_err = 0; busy_err = 0;
    for (int n = 1; n <= n_edges; n++) begin
      if (n == pulse_at) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      v = sel ? {A1, B1, C1} : {A0, B0, C0};
      d = sel ? done1 : done0;
      b = sel ? busy1 : busy0;
      if (d) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      ev = n / (s + 1);
      if (ev > 7) ev = 7;
      if (v != 3'(ev)) vec_err++;
      if (b != (n <= 8 * (s + 1))) busy_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if ({A0, B0, C0, busy0, done0, pass0, tbl0, mm0} !== 22'd0)
      $display("FAIL reset_outputs: got %h want 0", {A0, B0, C0, busy0, done0, pass0, tbl0, mm0});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_sweep();
    int de, dc, ve, be;
    start_sweep(0, 8'hD5);
    observe(0, 4, 43, -1, de, dc, ve, be);
    total_cnt++;
    if (de + 1 !== 41) $display("FAIL full_done_cycle: got %0d want 41", de + 1);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 1) $display("FAIL full_done_count: got %0d want 1", dc);
    else pass_cnt++;
    total_cnt++;
    if (tbl0 !== 8'hD5) $display("FAIL full_table: got %h want d5", tbl0);
    else pass_cnt++;
    total_cnt++;
    if (pass0 !== 1'b1) $display("FAIL full_pass: got %b want 1", pass0);
    else pass_cnt++;
    total_cnt++;
    if (mm0 !== 8'h00) $display("FAIL full_mismatch: got %h want 00", mm0);
    else pass_cnt++;
    total_cnt++;
    if (be !== 0) $display("FAIL full_busy: got %0d bad cycles want 0", be);
    else pass_cnt++;
  endtask

  task automatic test_mismatch();
    int de, dc, ve, be;
    start_sweep(0, 8'hD4);
    observe(0, 4, 43, -1, de, dc, ve, be);
    total_cnt++;
    if (pass0 !== 1'b0) $display("FAIL mm_pass: got %b want 0", pass0);
    else pass_cnt++;
    total_cnt++;
    if (mm0 !== 8'h01) $display("FAIL mm_mismatch: got %h want 01", mm0);
    else pass_cnt++;
    total_cnt++;
    if (tbl0 !== 8'hD5) $display("FAIL mm_table: got %h want d5", tbl0);
    else pass_cnt++;
  endtask

  task automatic test_vector_order();
    int de, dc, ve, be;
    start_sweep(0, 8'hD5);
    observe(0, 4, 50, -1, de, dc, ve, be);
    total_cnt++;
    if (ve !== 0) $display("FAIL vec_order: got %0d bad cycles want 0", ve);
    else pass_cnt++;
    total_cnt++;
    if ({A0, B0, C0} !== 3'b111) $display("FAIL vec_hold_after_done: got %b want 111", {A0, B0, C0});
    else pass_cnt++;
  endtask

  task automatic test_busy_protect();
    int de, dc, ve, be;
    start_sweep(0, 8'hD5);
    observe(0, 4, 45, 12, de, dc, ve, be);
    total_cnt++;
    if (dc !== 1) $display("FAIL busy_done_count: got %0d want 1", dc);
    else pass_cnt++;
    total_cnt++;
    if (de + 1 !== 41) $display("FAIL busy_done_cycle: got %0d want 41", de + 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   cnt, e1, e2;
    logic b41, b42;
    logic [2:0] v42;
    cnt = 0; e1 = -1; e2 = -1; b41 = 1'b1; b42 = 1'b0; v42 = 3'b111;
    @(negedge clk);
    start0 = 1'b1;
    exp0 = 8'hD5;
    @(posedge clk); #1;
    for (int n = 1; n <= 90; n++) begin
      @(posedge clk); #1;
      if (n == 41) b41 = busy0;
      if (n == 42) begin
        b42 = busy0;
        v42 = {A0, B0, C0};
        start0 = 1'b0;
      end
      if (done0) begin
        cnt++;
        if (e1 < 0) e1 = n; else if (e2 < 0) e2 = n;
      end
    end
    total_cnt++;
    if (cnt !== 2) $display("FAIL b2b_done_count: got %0d want 2", cnt);
    else pass_cnt++;
    total_cnt++;
    if (b41 !== 1'b0 || b42 !== 1'b1) $display("FAIL b2b_busy_gap: got %b%b want 01", b41, b42);
    else pass_cnt++;
    total_cnt++;
    if (e2 !== 82 || v42 !== 3'b000) $display("FAIL b2b_restart: got edge %0d vec %b want 82 000", e2, v42);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int   dc;
    logic b28;
    logic [2:0] v28;
    dc = 0;
    start_sweep(0, 8'hAA);
    for (int n = 1; n <= 27; n++) begin
      @(posedge clk); #1;
    end
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    b28 = busy0;
    v28 = {A0, B0, C0};
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done0) dc++;
    end
    total_cnt++;
    if (b28 !== 1'b0 || v28 !== 3'b000) $display("FAIL abort_idle: got busy %b vec %b want 0 000", b28, v28);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 0) $display("FAIL abort_no_done: got %0d want 0", dc);
    else pass_cnt++;
    total_cnt++;
    if (tbl0 !== 8'h15) $display("FAIL abort_partial_table: got %h want 15", tbl0);
    else pass_cnt++;
    total_cnt++;
    if (pass0 !== 1'b1 || mm0 !== 8'h00) $display("FAIL abort_keep_result: got %b %h want 1 00", pass0, mm0);
    else pass_cnt++;
    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b0 || tbl0 !== 8'h15) $display("FAIL abort_over_start: got busy %b table %h want 0 15", busy0, tbl0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int dc, be, ve;
    dc = 0; be = 0; ve = 0;
    start_sweep(0, 8'hD5);
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({A0, B0, C0, busy0, done0, pass0, tbl0, mm0} !== 22'd0)
      $display("FAIL rst_mid_outputs: got %h want 0", {A0, B0, C0, busy0, done0, pass0, tbl0, mm0});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done0) dc++;
      if (busy0) be++;
      if ({A0, B0, C0} != 3'b000) ve++;
    end
    total_cnt++;
    if (dc !== 0 || be !== 0 || ve !== 0)
      $display("FAIL rst_mid_idle: got done %0d busy %0d vec %0d want 0 0 0", dc, be, ve);
    else pass_cnt++;
  endtask

  task automatic test_boundary_s1();
    int de, dc, ve, be;
    start_sweep(1, 8'hD5);
    observe(1, 1, 19, -1, de, dc, ve, be);
    total_cnt++;
    if (de + 1 !== 17) $display("FAIL s1_done_cycle: got %0d want 17", de + 1);
    else pass_cnt++;
    total_cnt++;
    if (ve !== 0 || be !== 0) $display("FAIL s1_vec_busy: got %0d %0d bad cycles want 0 0", ve, be);
    else pass_cnt++;
    total_cnt++;
    if (tbl1 !== 8'hD5 || pass1 !== 1'b1) $display("FAIL s1_result: got %h %b want d5 1", tbl1, pass1);
    else pass_cnt++;
    start_sweep(1, 8'h55);
    observe(1, 1, 19, -1, de, dc, ve, be);
    total_cnt++;
    if (pass1 !== 1'b0 || mm1 !== 8'h80) $display("FAIL s1_mismatch: got %b %h want 0 80", pass1, mm1);
    else pass_cnt++;
  endtask

  initial begin
    start0 = 1'b0; abort0 = 1'b0; exp0 = 8'h00;
    start1 = 1'b0; abort1 = 1'b0; exp1 = 8'h00;
    test_reset();
    test_full_sweep();
    test_mismatch();
    test_vector_order();
    test_busy_protect();
    test_back_to_back();
    test_abort();
    test_reset_mid_sweep();
    test_boundary_s1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
